// File: rtl/vga_pkg.sv
// Purpose: shared types and constants for the VGA clocking/reset slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

  // PLL acquisition sequencer states
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_t;

  localparam int REFCLK_HZ = 50_000_000;

  // Default timing in refclk cycles
  localparam int DEF_RST_CYCLES    = 50;     // 1 us PLL reset pulse
  localparam int DEF_LOCK_TIMEOUT  = 50_000; // 1 ms lock window
  localparam int DEF_STABLE_CYCLES = 1024;   // lock qualification window
  localparam int DEF_MAX_RETRY     = 3;      // retries after the first attempt

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: generic 2-flop single-bit synchronizer, async active-low reset to 0.
// Latency: 2 destination clock edges from a stable input to o_q.
// Backpressure: none; level signal, no handshake.
//
// Ports:
//   i_clk   destination clock
//   i_rst_n asynchronous active-low reset (clears both flops)
//   i_d     asynchronous input bit
//   o_q     synchronized output
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Purpose: pixel PLL power-up/recovery sequencer: reset pulse, timed lock wait with retries,
//          lock qualification, then releases the downstream system reset.
// Latency: release RST_CYCLES+2+1+STABLE_CYCLES refclk cycles after rst_n for an instantly locking PLL.
// Backpressure: none; relock_req is a single-cycle strobe, all outputs are registered levels.
//
// Ports:
//   refclk      50 MHz free-running reference clock
//   rst_n       asynchronous active-low reset
//   pll_locked  PLL lock indicator (asynchronous, synchronized internally)
//   relock_req  single-cycle request to restart sequencing
//   pll_rst     PLL reset, active-high (high in PLL_RST)
//   sys_rst_n   downstream reset, active-low (high only in RUN)
//   ready       high only in RUN
//   fail        high only in FAIL
//   retry_cnt   retries used in the current acquisition attempt
//   loss_cnt    lock-loss events seen in RUN, saturating at 255
module pll_lock_sequencer
  import vga_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_retry;
  logic [7:0]       r_loss;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_ready;
  logic             r_fail;

  logic w_lock_s;
  logic w_cnt_clr;
  logic w_retry_inc;
  logic w_retry_clr;
  logic w_loss_inc;

  sync_2ff u_lock_sync (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  // Next-state logic. relock_req is checked first everywhere so it wins over
  // lock loss (no loss_cnt bump) and over timeouts.
  always_comb begin
    w_next      = r_state;
    w_cnt_clr   = 1'b0;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_loss_inc  = 1'b0;

    case (r_state)
      PLL_RST: begin
        if (relock_req) begin
          w_cnt_clr = 1'b1;             // restart the pulse, stay put
        end else if (r_cnt == RST_LAST) begin
          w_next = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (relock_req) begin
          w_next      = PLL_RST;
          w_retry_clr = 1'b1;
        end else if (w_lock_s) begin
          w_next = STABLE;              // lock beats a same-cycle timeout
        end else if (r_cnt == TMO_LAST) begin
          if (r_retry == RETRY_MAX) begin
            w_next = FAIL;
          end else begin
            w_next      = PLL_RST;
            w_retry_inc = 1'b1;
          end
        end
      end
      STABLE: begin
        if (relock_req) begin
          w_next      = PLL_RST;
          w_retry_clr = 1'b1;
        end else if (!w_lock_s) begin
          w_next = WAIT_LOCK;           // glitch: fresh timeout, no retry spent
        end else if (r_cnt == STB_LAST) begin
          w_next      = RUN;
          w_retry_clr = 1'b1;
        end
      end
      RUN: begin
        if (relock_req) begin
          w_next      = PLL_RST;
          w_retry_clr = 1'b1;
        end else if (!w_lock_s) begin
          w_next     = PLL_RST;
          w_loss_inc = 1'b1;
        end
      end
      FAIL: begin
        if (relock_req) begin
          w_next      = PLL_RST;
          w_retry_clr = 1'b1;
        end
      end
      default: begin
        w_next = PLL_RST;
      end
    endcase

    if (w_next != r_state) begin
      w_cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PLL_RST;
      r_cnt       <= '0;
      r_retry     <= 4'd0;
      r_loss      <= 8'd0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state <= w_next;

      // Counter only runs in the timed states; it idles at 0 in RUN/FAIL.
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_state == PLL_RST || r_state == WAIT_LOCK || r_state == STABLE) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_retry_clr) begin
        r_retry <= 4'd0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 4'd1;
      end

      if (w_loss_inc && (r_loss != 8'hFF)) begin
        r_loss <= r_loss + 8'd1;
      end

      // Decoded from the next state so outputs change on the same edge as the state.
      r_pll_rst   <= (w_next == PLL_RST);
      r_sys_rst_n <= (w_next == RUN);
      r_ready     <= (w_next == RUN);
      r_fail      <= (w_next == FAIL);
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign retry_cnt = r_retry;
  assign loss_cnt  = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Purpose: self-checking bench for pll_lock_sequencer with short timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       lk_drv = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  // PLL model: it can only report lock while its reset is released.
  assign pll_locked = lk_drv & ~pll_rst;

  always #10 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  typedef struct packed {
    logic       prst;
    logic       srn;
    logic       rdy;
    logic       fl;
    logic [3:0] retry;
    logic [7:0] loss;
  } obs_t;

  typedef struct {
    bit   rst;   // apply a fresh reset before this row
    int   n;     // number of cycles this row lasts
    bit   lk;
    bit   rq;
    obs_t exp;
  } row_t;

  row_t tbl[$];
  obs_t sb[$];
  obs_t act;
  int   n_checks = 0;
  int   n_fail = 0;
  int   lc;
  int   wn;

  assign act = {pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt};

  function automatic obs_t o(bit p, bit s, bit r, bit f, int rt, int ls);
    obs_t x;
    x.prst  = p;
    x.srn   = s;
    x.rdy   = r;
    x.fl    = f;
    x.retry = 4'(rt);
    x.loss  = 8'(ls);
    return x;
  endfunction

  task automatic add(input bit rs, input int n, input bit lk, input bit rq, input obs_t e);
    row_t r;
    r.rst = rs;
    r.n   = n;
    r.lk  = lk;
    r.rq  = rq;
    r.exp = e;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got prst=%0b srn=%0b rdy=%0b fl=%0b retry=%0d loss=%0d, expected prst=%0b srn=%0b rdy=%0b fl=%0b retry=%0d loss=%0d",
               name, got.prst, got.srn, got.rdy, got.fl, got.retry, got.loss,
               exp.prst, exp.srn, exp.rdy, exp.fl, exp.retry, exp.loss);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One cycle: drive inputs mid-cycle, queue the expectation, sample, advance.
  task automatic cyc(input bit lk, input bit rq, input obs_t e, input string name);
    obs_t x;
    lk_drv     = lk;
    relock_req = rq;
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    check(name, act, x);
    @(negedge refclk);
  endtask

  // Leaves rst_n released at a falling edge: the following interval is cycle 0.
  task automatic do_reset();
    rst_n      = 1'b0;
    lk_drv     = 1'b0;
    relock_req = 1'b0;
    @(negedge refclk);
    #1;
    check("reset_state", act, o(1, 0, 0, 0, 0, 0));
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Immediate lock: pll_rst cycles 0..3, release at cycle 15
    add(1, 4,  1, 0, o(1, 0, 0, 0, 0, 0));
    add(0, 11, 1, 0, o(0, 0, 0, 0, 0, 0));
    add(0, 3,  1, 0, o(0, 1, 1, 0, 0, 0));
    // relock_req during PLL_RST restarts the 4-cycle pulse
    add(1, 2,  1, 0, o(1, 0, 0, 0, 0, 0));
    add(0, 1,  1, 1, o(1, 0, 0, 0, 0, 0));
    add(0, 4,  1, 0, o(1, 0, 0, 0, 0, 0));
    add(0, 11, 1, 0, o(0, 0, 0, 0, 0, 0));
    add(0, 1,  1, 0, o(0, 1, 1, 0, 0, 0));
    // Never locks: three pulses, 20-cycle windows, then FAIL; relock recovers
    add(1, 4,  0, 0, o(1, 0, 0, 0, 0, 0));
    add(0, 20, 0, 0, o(0, 0, 0, 0, 0, 0));
    add(0, 4,  0, 0, o(1, 0, 0, 0, 1, 0));
    add(0, 20, 0, 0, o(0, 0, 0, 0, 1, 0));
    add(0, 4,  0, 0, o(1, 0, 0, 0, 2, 0));
    add(0, 20, 0, 0, o(0, 0, 0, 0, 2, 0));
    add(0, 5,  0, 0, o(0, 0, 0, 1, 2, 0));
    add(0, 1,  1, 1, o(0, 0, 0, 1, 2, 0));
    add(0, 4,  1, 0, o(1, 0, 0, 0, 0, 0));
    add(0, 11, 1, 0, o(0, 0, 0, 0, 0, 0));
    add(0, 2,  1, 0, o(0, 1, 1, 0, 0, 0));
    // Glitchy lock: 5 high / 3 low, three times, then steady
    add(1, 4,  0, 0, o(1, 0, 0, 0, 0, 0));
    for (int g = 0; g < 3; g++) begin
      add(0, 5, 1, 0, o(0, 0, 0, 0, 0, 0));
      add(0, 3, 0, 0, o(0, 0, 0, 0, 0, 0));
    end
    add(0, 11, 1, 0, o(0, 0, 0, 0, 0, 0));
    add(0, 2,  1, 0, o(0, 1, 1, 0, 0, 0));
    // Loss in RUN: reset falls 3 cycles after the drop, loss_cnt=1, new pulse
    add(0, 3,  0, 0, o(0, 1, 1, 0, 0, 0));
    add(0, 4,  1, 0, o(1, 0, 0, 0, 0, 1));
    add(0, 11, 1, 0, o(0, 0, 0, 0, 0, 1));
    add(0, 2,  1, 0, o(0, 1, 1, 0, 0, 1));
    // relock_req on the cycle lock_s falls: no loss counted
    add(0, 2,  0, 0, o(0, 1, 1, 0, 0, 1));
    add(0, 1,  0, 1, o(0, 1, 1, 0, 0, 1));
    add(0, 4,  1, 0, o(1, 0, 0, 0, 0, 1));
    add(0, 11, 1, 0, o(0, 0, 0, 0, 0, 1));
    add(0, 2,  1, 0, o(0, 1, 1, 0, 0, 1));

    #2;
    for (int r = 0; r < tbl.size(); r++) begin
      if (tbl[r].rst) do_reset();
      for (int k = 0; k < tbl[r].n; k++) begin
        cyc(tbl[r].lk, tbl[r].rq, tbl[r].exp, $sformatf("row%0d.%0d", r, k));
      end
    end

    // Repeated lock losses: loss_cnt counts up and saturates at 255
    for (int i = 0; i < 300; i++) begin
      lc = (i + 2 > 255) ? 255 : i + 2;
      sb.push_back(o(0, 1, 1, 0, 0, lc));
      lk_drv = 1'b0;
      repeat (3) @(negedge refclk);
      lk_drv = 1'b1;
      wn = 0;
      while (!ready && wn < 40) begin
        @(negedge refclk);
        wn++;
      end
      #1;
      check($sformatf("loss_iter%0d", i), act, sb.pop_front());
      @(negedge refclk);
    end

    // Async reset in the middle of STABLE
    lk_drv = 1'b0;
    repeat (3) @(negedge refclk);
    lk_drv = 1'b1;
    repeat (9) @(negedge refclk);
    #1;
    check("pre_arst_stable", act, o(0, 0, 0, 0, 0, 255));
    #4;
    rst_n = 1'b0;
    #1;
    check("arst_immediate", act, o(1, 0, 0, 0, 0, 0));
    @(negedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    wn = 0;
    while (!ready && wn < 40) begin
      @(negedge refclk);
      wn++;
    end
    check_int("release_after_arst", wn, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
